// File: rtl/top_pkg.sv
// Shared constants and types for the generator / skid-buffer / checker slice.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package top_pkg;

    // Default payload and sequence-counter width.
    localparam int unsigned DEFAULT_DATA_WIDTH = 32;

    // Data word at the default width.
    typedef logic [DEFAULT_DATA_WIDTH-1:0] word_t;

endpackage : top_pkg

// File: rtl/top_skid_buffer.sv
// Two-entry valid/ready FIFO between generator and checker.
// Latency: a word pushed at edge N is visible on the output from cycle N+1 when empty.
// Backpressure: in_ready_o is registered and high whenever at least one entry is free.
//
// Ports:
//   clk, rst_n              clock and asynchronous active-low reset
//   in_valid_i/in_data_i    upstream payload
//   in_ready_o              upstream ready (registered)
//   out_valid_o/out_data_o  downstream payload
//   out_ready_i             downstream ready
module top_skid_buffer #(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid_i,
    input  logic [DATA_WIDTH-1:0] in_data_i,
    output logic                  in_ready_o,
    output logic                  out_valid_o,
    output logic [DATA_WIDTH-1:0] out_data_o,
    input  logic                  out_ready_i
);

    logic [DATA_WIDTH-1:0] mem0_q, mem1_q;
    logic                  wr_ptr_q, wr_ptr_d;
    logic                  rd_ptr_q, rd_ptr_d;
    logic [1:0]            cnt_q, cnt_d;
    logic                  in_rdy_q, in_rdy_d;
    logic                  push, pop;

    assign push        = in_valid_i & in_rdy_q;
    assign pop         = out_valid_o & out_ready_i;
    assign in_ready_o  = in_rdy_q;
    assign out_valid_o = (cnt_q != 2'd0);
    assign out_data_o  = rd_ptr_q ? mem1_q : mem0_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (push) begin
            wr_ptr_d = ~wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + 2'd1;
            2'b01:   cnt_d = cnt_q - 2'd1;
            default: cnt_d = cnt_q;
        endcase
        // Ready is computed from next occupancy so the registered flag is exact
        // (never advertises space that does not exist, never hides a free slot).
        in_rdy_d = (cnt_d != 2'd2);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem0_q   <= '0;
            mem1_q   <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            cnt_q    <= 2'd0;
            in_rdy_q <= 1'b0;
        end else begin
            if (push && !wr_ptr_q) begin
                mem0_q <= in_data_i;
            end
            if (push && wr_ptr_q) begin
                mem1_q <= in_data_i;
            end
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            in_rdy_q <= in_rdy_d;
        end
    end

endmodule : top_skid_buffer

// File: rtl/top.sv
// Sequence generator -> 2-entry skid buffer -> sequence checker, all links valid/ready.
// Latency: word leaves generator at edge N, reaches checker port at cycle N+1 when buffer empty.
// Backpressure: generator stalls holding valid/data while buffer full; checker throttles via DELAY_CHK.
//
// Ports: clk (rising edge), rst (async, active low); gen_down_* observe the generator link,
// chk_up_* observe the checker link.
// Optional build macro TOP_CHECK_EN: adds the expected-value compare, a sticky
// error flag (chk_err_q) and a simulation message on the first mismatch.
module top
    import top_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int unsigned DELAY_GEN  = 0,
    parameter int unsigned DELAY_CHK  = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  gen_down_valid,
    output logic [DATA_WIDTH-1:0] gen_down_data,
    output logic                  gen_down_ready,
    output logic                  chk_up_valid,
    output logic [DATA_WIDTH-1:0] chk_up_data,
    output logic                  chk_up_ready
);

    // ---------------- generator ----------------
    logic                  gen_vld_q, gen_vld_d;
    logic [DATA_WIDTH-1:0] seq_q, seq_d;
    logic [31:0]           gen_gap_q, gen_gap_d;
    logic                  gen_xfer;

    assign gen_xfer       = gen_vld_q & gen_down_ready;
    assign gen_down_valid = gen_vld_q;
    assign gen_down_data  = seq_q;

    always_comb begin
        gen_vld_d = gen_vld_q;
        seq_d     = seq_q;
        gen_gap_d = gen_gap_q;
        if (gen_xfer) begin
            seq_d = seq_q + DATA_WIDTH'(1);
            if (DELAY_GEN == 0) begin
                gen_vld_d = 1'b1;
            end else begin
                // The cycle after the transfer is the first idle cycle.
                gen_vld_d = 1'b0;
                gen_gap_d = DELAY_GEN - 32'd1;
            end
        end else if (!gen_vld_q) begin
            if (gen_gap_q == 32'd0) begin
                gen_vld_d = 1'b1;
            end else begin
                gen_gap_d = gen_gap_q - 32'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            gen_vld_q <= 1'b0;
            seq_q     <= '0;
            // Loading the full gap makes the first word appear DELAY_GEN cycles late.
            gen_gap_q <= DELAY_GEN;
        end else begin
            gen_vld_q <= gen_vld_d;
            seq_q     <= seq_d;
            gen_gap_q <= gen_gap_d;
        end
    end

    // ---------------- buffer ----------------
    top_skid_buffer #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_buf (
        .clk         (clk),
        .rst_n       (rst),
        .in_valid_i  (gen_vld_q),
        .in_data_i   (seq_q),
        .in_ready_o  (gen_down_ready),
        .out_valid_o (chk_up_valid),
        .out_data_o  (chk_up_data),
        .out_ready_i (chk_up_ready)
    );

    // ---------------- checker ----------------
    logic                  chk_rdy_q, chk_rdy_d;
    logic [31:0]           chk_cnt_q, chk_cnt_d;
    logic [DATA_WIDTH-1:0] exp_q, exp_d;
    logic                  chk_xfer;

    assign chk_xfer     = chk_up_valid & chk_rdy_q;
    assign chk_up_ready = chk_rdy_q;

    always_comb begin
        chk_rdy_d = chk_rdy_q;
        chk_cnt_d = chk_cnt_q;
        exp_d     = exp_q;
        if (chk_xfer) begin
            exp_d = exp_q + DATA_WIDTH'(1);
            if (DELAY_CHK == 0) begin
                chk_rdy_d = 1'b1;
            end else begin
                chk_rdy_d = 1'b0;
                chk_cnt_d = DELAY_CHK - 32'd1;
            end
        end else if (!chk_rdy_q) begin
            if (chk_cnt_q == 32'd0) begin
                chk_rdy_d = 1'b1;
            end else begin
                chk_cnt_d = chk_cnt_q - 32'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            chk_rdy_q <= 1'b0;
            chk_cnt_q <= 32'd0;
            exp_q     <= '0;
        end else begin
            chk_rdy_q <= chk_rdy_d;
            chk_cnt_q <= chk_cnt_d;
            exp_q     <= exp_d;
        end
    end

`ifdef TOP_CHECK_EN
    logic chk_err_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            chk_err_q <= 1'b0;
        end else if (chk_xfer && (chk_up_data != exp_q)) begin
            chk_err_q <= 1'b1;
            if (!chk_err_q) begin
                $error("top checker: got %0h expected %0h", chk_up_data, exp_q);
            end
        end
    end
`else
`endif

endmodule : top

// File: tb/tb_top.sv
module tb_top;

    logic clk;
    logic rst;
    int   checks;
    int   passes;
    int   fails;

    // default instance
    logic        d0_gv, d0_gr, d0_cv, d0_cr;
    logic [31:0] d0_gd, d0_cd;
    // DELAY_GEN=2
    logic        g2_gv, g2_gr, g2_cv, g2_cr;
    logic [31:0] g2_gd, g2_cd;
    // DELAY_CHK=3
    logic        c3_gv, c3_gr, c3_cv, c3_cr;
    logic [31:0] c3_gd, c3_cd;
    // DATA_WIDTH=4
    logic        w4_gv, w4_gr, w4_cv, w4_cr;
    logic [3:0]  w4_gd, w4_cd;

    top u_d0 (.clk(clk), .rst(rst),
        .gen_down_valid(d0_gv), .gen_down_data(d0_gd), .gen_down_ready(d0_gr),
        .chk_up_valid(d0_cv), .chk_up_data(d0_cd), .chk_up_ready(d0_cr));

    top #(.DELAY_GEN(2)) u_g2 (.clk(clk), .rst(rst),
        .gen_down_valid(g2_gv), .gen_down_data(g2_gd), .gen_down_ready(g2_gr),
        .chk_up_valid(g2_cv), .chk_up_data(g2_cd), .chk_up_ready(g2_cr));

    top #(.DELAY_CHK(3)) u_c3 (.clk(clk), .rst(rst),
        .gen_down_valid(c3_gv), .gen_down_data(c3_gd), .gen_down_ready(c3_gr),
        .chk_up_valid(c3_cv), .chk_up_data(c3_cd), .chk_up_ready(c3_cr));

    top #(.DATA_WIDTH(4)) u_w4 (.clk(clk), .rst(rst),
        .gen_down_valid(w4_gv), .gen_down_data(w4_gd), .gen_down_ready(w4_gr),
        .chk_up_valid(w4_cv), .chk_up_data(w4_cd), .chk_up_ready(w4_cr));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // advance one cycle and sample at the following falling edge
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " gv"}, {31'd0, d0_gv}, 32'd0);
        check({tag, " gd"}, d0_gd, 32'd0);
        check({tag, " gr"}, {31'd0, d0_gr}, 32'd0);
        check({tag, " cv"}, {31'd0, d0_cv}, 32'd0);
        check({tag, " cd"}, d0_cd, 32'd0);
        check({tag, " cr"}, {31'd0, d0_cr}, 32'd0);
    endtask

    initial begin
        checks = 0;
        passes = 0;
        fails  = 0;
        rst    = 1'b0;

        // ---- reset state ----
        repeat (3) step();
        check_all_zero("rst0");
        check("rst0 c3 cr", {31'd0, c3_cr}, 32'd0);
        check("rst0 w4 cd", {28'd0, w4_cd}, 32'd0);

        rst = 1'b1;   // released at a falling edge; cycle c = after c-th rising edge

        for (int c = 1; c <= 80; c++) begin
            step();
            // default instance: back-to-back, data k-2 from cycle 2
            check("d0 gv", {31'd0, d0_gv}, 32'd1);
            check("d0 gr", {31'd0, d0_gr}, 32'd1);
            check("d0 cr", {31'd0, d0_cr}, 32'd1);
            check("d0 gd", d0_gd, 32'(c - 1));
            if (c == 1) begin
                check("d0 cv first", {31'd0, d0_cv}, 32'd0);
            end else begin
                check("d0 cv", {31'd0, d0_cv}, 32'd1);
                check("d0 cd", d0_cd, 32'(c - 2));
                check("w4 cd wrap", {28'd0, w4_cd}, 32'((c - 2) % 16));
                check("w4 cv", {31'd0, w4_cv}, 32'd1);
            end

            // DELAY_GEN=2: valid at cycles 3,6,9,...; word k seen by checker at 4+3k
            check("g2 gv", {31'd0, g2_gv}, ((c >= 3) && ((c - 3) % 3 == 0)) ? 32'd1 : 32'd0);
            check("g2 cv", {31'd0, g2_cv}, ((c >= 4) && ((c - 4) % 3 == 0)) ? 32'd1 : 32'd0);
            if ((c >= 4) && ((c - 4) % 3 == 0)) begin
                check("g2 cd", g2_cd, 32'((c - 4) / 3));
            end

            // DELAY_CHK=3: word k accepted by checker during cycle 2+4k
            if ((c >= 2) && ((c - 2) % 4 == 0)) begin
                check("c3 cr", {31'd0, c3_cr}, 32'd1);
                check("c3 cv", {31'd0, c3_cv}, 32'd1);
                check("c3 cd", c3_cd, 32'((c - 2) / 4));
            end
            if (c >= 3 && c <= 5) begin
                check("c3 cr low", {31'd0, c3_cr}, 32'd0);
            end
            if (c >= 4 && c <= 6) begin
                check("c3 gr full", {31'd0, c3_gr}, 32'd0);
            end
            if (c >= 4 && c <= 7) begin
                check("c3 gd stall", c3_gd, 32'd3);
                check("c3 gv stall", {31'd0, c3_gv}, 32'd1);
            end
        end

        // ---- reset pulse mid-stream ----
        rst = 1'b0;
        #1;
        check_all_zero("rstmid async");
        step();
        step();
        check_all_zero("rstmid hold");
        check("rstmid g2 gv", {31'd0, g2_gv}, 32'd0);
        rst = 1'b1;
        step();
        check("restart gv", {31'd0, d0_gv}, 32'd1);
        check("restart gd", d0_gd, 32'd0);
        check("restart cv", {31'd0, d0_cv}, 32'd0);
        for (int c = 2; c <= 6; c++) begin
            step();
            check("restart cd", d0_cd, 32'(c - 2));
        end

`ifdef TOP_CHECK_EN
        // cycle 6 now presents word 4; rewind to find the cycle where 3 is at the port
        rst = 1'b0;
        step();
        rst = 1'b1;
        for (int c = 1; c <= 4; c++) step();   // cycle 4 : checker port shows 2
        check("err clean", {31'd0, u_d0.chk_err_q}, 32'd0);
        step();                                 // cycle 5 : port shows 3
        force u_d0.chk_up_data = 32'd5;
        step();
        release u_d0.chk_up_data;
        check("err set", {31'd0, u_d0.chk_err_q}, 32'd1);
        repeat (4) step();
        check("err sticky", {31'd0, u_d0.chk_err_q}, 32'd1);
`endif

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule : tb_top

// File: doc/top.md
TOP -- requirements
Module: top

Interface
REQ-001 Parameter DATA_WIDTH, default 32, width of payload and sequence counter.
REQ-002 Parameter DELAY_GEN, default 0, idle cycles the generator inserts after each accepted word.
REQ-003 Parameter DELAY_CHK, default 0, cycles the checker holds ready low after each accepted word.
REQ-004 One clock; reset is asynchronous and active-low.
REQ-005 clk  input  1  sole clock, all state on rising edge.
REQ-006 rst  input  1  asynchronous active-low reset.
REQ-007 gen_down_valid  output  1  generator-to-buffer valid, for observation.
REQ-008 gen_down_data  output  DATA_WIDTH  generator-to-buffer payload.
REQ-009 gen_down_ready  output  1  buffer-to-generator ready.
REQ-010 chk_up_valid  output  1  buffer-to-checker valid.
REQ-011 chk_up_data  output  DATA_WIDTH  buffer-to-checker payload.
REQ-012 chk_up_ready  output  1  checker-to-buffer ready.

Function
REQ-013 Transfer on a link occurs when valid and ready are both high at a rising clk edge.
REQ-014 Generator: sequence counter starts at 0 and increments by 1 per accepted word, wrapping from 2^DATA_WIDTH-1 to 0.
REQ-015 Generator: once valid is high, valid and data stay stable until transfer; valid never depends combinationally on ready.
REQ-016 Generator: after a transfer, valid is low for exactly DELAY_GEN cycles; with DELAY_GEN=0, words go back-to-back.
REQ-017 Buffer: 2-entry skid buffer; gen_down_ready is high when at least one entry is free and is driven from a register.
REQ-018 Buffer: word accepted at edge N is presented on chk_up at cycle N+1 when empty; order is strictly FIFO, no loss, no duplication.
REQ-019 Buffer: simultaneous push and pop while non-empty keeps occupancy unchanged; full throughput is one word per cycle.
REQ-020 Checker: after a transfer, chk_up_ready is low for exactly DELAY_CHK cycles and then high until the next transfer; with DELAY_CHK=0, it is always high out of reset.
REQ-021 Checker: expected counter starts at 0 and increments (wrapping) per accepted word.

Reset
REQ-022 While rst is low: gen_down_valid=0, gen_down_data=0, chk_up_valid=0, chk_up_data=0, chk_up_ready=0, gen_down_ready=0, both buffer entries empty, both counters 0.
REQ-023 Reset asserted mid-transfer discards buffered words; after release, the sequence restarts at 0.
REQ-024 In the first cycle after release, generator valid is high when DELAY_GEN=0, otherwise after DELAY_GEN cycles.

Configuration
REQ-025 With macro TOP_CHECK_EN defined, the checker compares every accepted word with the expected counter, keeps a sticky internal error flag and issues a simulation error message on the first mismatch.
REQ-026 Without TOP_CHECK_EN, the comparison, flag and message are absent; the handshake behaviour is identical.

Structure
REQ-027 Package top_pkg holds the default DATA_WIDTH constant and the data word typedef.
REQ-028 Natural sub-module: top_skid_buffer (2-entry valid/ready buffer); the generator and checker are in top.

Verification
REQ-029 Defaults, 80 cycles after reset -> chk_up_data shows 0,1,2,... one per cycle from cycle 2; gen_down_ready is constantly 1; there are no mismatches.
REQ-030 DELAY_GEN=2, DELAY_CHK=0 -> gen_down_valid follows the pattern 1,0,0 repeating; the checker receives 0,1,2,... with no errors.
REQ-031 DELAY_GEN=0, DELAY_CHK=3 -> the buffer fills, gen_down_ready drops, and gen_down_data stays stable while stalled; the sequence is received intact.
REQ-032 DATA_WIDTH=4, defaults -> counter wraps 15 to 0 on both sides without a mismatch.
REQ-033 rst pulsed low for 2 cycles mid-stream -> all outputs are 0 while rst is low, and the sequence restarts at 0 after release.
REQ-034 With TOP_CHECK_EN, a forced corruption of chk_up_data to 5 when 3 is expected -> the error flag sets and stays set.
